// File: rtl/normalizer_pipe_if.sv
// Valid/ready bus for normalizer_pipe: an input beat channel and a normalised result channel.
// The master drives beats and consumes results; the slave is the normaliser itself.
interface normalizer_pipe_if #(
  parameter int unsigned FRAC_WIDTH = 49,
  parameter int unsigned EXP_WIDTH  = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [FRAC_WIDTH-1:0] in_fraction;
  logic [EXP_WIDTH-1:0]  in_exponent;
  logic                  out_valid;
  logic                  out_ready;
  logic [FRAC_WIDTH-1:0] out_fraction;
  logic [EXP_WIDTH-1:0]  out_exponent;
  logic                  out_sticky;
  logic                  out_zero;
  logic                  out_denormal;

  modport master (
    output in_valid, in_fraction, in_exponent, out_ready,
    input  in_ready, out_valid, out_fraction, out_exponent, out_sticky, out_zero, out_denormal
  );

  modport slave (
    input  in_valid, in_fraction, in_exponent, out_ready,
    output in_ready, out_valid, out_fraction, out_exponent, out_sticky, out_zero, out_denormal
  );
endinterface

// File: rtl/normalizer_pipe.sv
// Two-stage fraction normaliser for a 2-integer-bit fraction: stage 1 classifies and picks the
// shift, stage 2 applies it, adjusts the exponent and flags zero/denormal results.
module normalizer_pipe #(
  parameter int unsigned FRAC_WIDTH = 49,
  parameter int unsigned EXP_WIDTH  = 10
) (
  input logic              clk,
  input logic              reset,
  normalizer_pipe_if.slave bus
);

  localparam int unsigned ShW = $clog2(FRAC_WIDTH);
  localparam int unsigned XW  = EXP_WIDTH + 1;
  localparam logic [EXP_WIDTH-1:0] ExpMax = {1'b0, {(EXP_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {ClsNormal, ClsOver, ClsUnder, ClsZero} cls_e;

  logic                  s1_valid_q, s2_valid_q;
  logic                  s1_adv, in_ready;
  cls_e                  s1_cls_q, s1_cls_d;
  logic [FRAC_WIDTH-1:0] s1_frac_q;
  logic [EXP_WIDTH-1:0]  s1_exp_q, s1_exp_d;
  logic [ShW-1:0]        s1_shift_q, s1_shift_d;
  logic                  s1_sticky_q, s1_sticky_d;
  logic [ShW-1:0]        lz;
  logic signed [XW-1:0]  em1, lz_x;

  logic [FRAC_WIDTH-1:0] out_frac_q, out_frac_d;
  logic [EXP_WIDTH-1:0]  out_exp_q, out_exp_d;
  logic                  out_sticky_q, out_zero_q, out_zero_d, out_dn_q, out_dn_d;

  assign s1_adv   = ~s2_valid_q | bus.out_ready;
  assign in_ready = reset | ~s1_valid_q | s1_adv;

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = s2_valid_q;
  assign bus.out_fraction = out_frac_q;
  assign bus.out_exponent = out_exp_q;
  assign bus.out_sticky   = out_sticky_q;
  assign bus.out_zero     = out_zero_q;
  assign bus.out_denormal = out_dn_q;

  // Stage 1: classify, count leading zeros below the integer MSB, clamp the left shift.
  always_comb begin
    s1_cls_d    = ClsNormal;
    s1_exp_d    = bus.in_exponent;
    s1_shift_d  = '0;
    s1_sticky_d = 1'b0;
    lz          = '0;
    for (int i = 0; i < int'(FRAC_WIDTH) - 1; i++) begin
      if (bus.in_fraction[i]) lz = ShW'(int'(FRAC_WIDTH) - 2 - i);
    end
    em1  = $signed({bus.in_exponent[EXP_WIDTH-1], bus.in_exponent}) - XW'(1);
    lz_x = $signed(XW'(lz));
    if (bus.in_fraction[FRAC_WIDTH-1]) begin
      s1_cls_d    = ClsOver;
      s1_sticky_d = bus.in_fraction[0];
      s1_exp_d    = (bus.in_exponent == ExpMax) ? ExpMax : bus.in_exponent + EXP_WIDTH'(1);
    end else if (bus.in_fraction[FRAC_WIDTH-2]) begin
      s1_cls_d = ClsNormal;
    end else if (bus.in_fraction == '0) begin
      s1_cls_d = ClsZero;
    end else begin
      s1_cls_d = ClsUnder;
      // em1 > 0 means E > 1; never shift the exponent below the minimum normal value.
      if (em1 > 0) s1_shift_d = (lz_x < em1) ? lz : ShW'(em1);
    end
  end

  // Stage 2: apply the shift and derive the result flags.
  always_comb begin
    out_frac_d = s1_frac_q;
    out_exp_d  = s1_exp_q;
    out_zero_d = 1'b0;
    case (s1_cls_q)
      ClsOver:  out_frac_d = {1'b0, s1_frac_q[FRAC_WIDTH-1:1]};
      ClsUnder: begin
        out_frac_d = s1_frac_q << s1_shift_q;
        out_exp_d  = s1_exp_q - EXP_WIDTH'(s1_shift_q);
      end
      ClsZero: begin
        out_frac_d = '0;
        out_exp_d  = '0;
        out_zero_d = 1'b1;
      end
      default: ;
    endcase
    out_dn_d = ~out_frac_d[FRAC_WIDTH-2] & ~out_zero_d;
    if (out_dn_d) out_exp_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s1_cls_q     <= ClsNormal;
      s1_frac_q    <= '0;
      s1_exp_q     <= '0;
      s1_shift_q   <= '0;
      s1_sticky_q  <= 1'b0;
      out_frac_q   <= '0;
      out_exp_q    <= '0;
      out_sticky_q <= 1'b0;
      out_zero_q   <= 1'b0;
      out_dn_q     <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_cls_q    <= s1_cls_d;
          s1_frac_q   <= bus.in_fraction;
          s1_exp_q    <= s1_exp_d;
          s1_shift_q  <= s1_shift_d;
          s1_sticky_q <= s1_sticky_d;
        end
      end
      if (s1_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_frac_q   <= out_frac_d;
          out_exp_q    <= out_exp_d;
          out_sticky_q <= s1_sticky_q;
          out_zero_q   <= out_zero_d;
          out_dn_q     <= out_dn_d;
        end
      end
    end
  end

endmodule
